requantizer: RTL and testbench

REQUANTIZER -- requirements
Module: requantizer

---
 rtl/wrd_quant_pkg.sv | 24 ++
 rtl/requantizer_lane.sv | 92 +++++++++
 rtl/requantizer.sv | 139 +++++++++++++
 tb/tb_requantizer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrd_quant_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wrd_quant_pkg
//  Purpose  : Shared rounding-mode encodings and saturation-bound helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package wrd_quant_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } round_mode_e;

    // Largest representable output; the unsigned variant shares the signed ceiling.
    function automatic logic signed [63:0] sat_upper(input int unsigned o_bw);
        return (64'sd1 <<< (o_bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_lower(input int unsigned o_bw, input bit is_signed);
        return is_signed ? -(64'sd1 <<< (o_bw - 1)) : 64'sd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/requantizer_lane.sv
`default_nettype none
// ============================================================================
//  Module   : requantizer_lane
//  Purpose  : One element: round+shift register (S1), clamp+saturate register (S2).
//  Revision : 1.0 - initial release
// ============================================================================
module requantizer_lane
    import wrd_quant_pkg::*;
#(
    parameter int I_BW     = 32,
    parameter int O_BW     = 8,
    parameter int SHIFT_BW = $clog2(I_BW),
    parameter int SIGNED   = 1,
    parameter int RELU     = 0,
    parameter int ROUND    = 1
) (
    input  logic                clk,
    input  logic [I_BW-1:0]     elem,
    input  logic [SHIFT_BW-1:0] shift,
    input  logic                s1_load,
    input  logic                s2_load,
    output logic [O_BW-1:0]     quant,
    output logic                sat
);

    localparam int                      XW     = I_BW + 1;
    localparam logic signed [63:0]      C_HI64 = sat_upper(O_BW);
    localparam logic signed [63:0]      C_LO64 = sat_lower(O_BW, SIGNED != 0);
    localparam logic signed [XW-1:0]    C_HI   = C_HI64[XW-1:0];
    localparam logic signed [XW-1:0]    C_LO   = C_LO64[XW-1:0];
    localparam bit                      C_RND  = (ROUND == int'(RND_HALF_UP));

    logic signed [XW-1:0] w_ext;
    logic signed [XW-1:0] w_rnd;
    logic signed [XW-1:0] w_sum;
    logic signed [XW-1:0] w_shr;
    logic signed [XW-1:0] r_s1;
    logic [O_BW-1:0]      w_clamp;
    logic                 w_sat;
    logic [O_BW-1:0]      r_q;
    logic                 r_sat;

    // One guard bit above I_BW absorbs the rounding increment without overflow.
    always_comb begin
        w_ext = (SIGNED != 0) ? {elem[I_BW-1], elem} : {1'b0, elem};
        w_rnd = '0;
        if (C_RND && (shift != '0)) begin
            w_rnd = {{I_BW{1'b0}}, 1'b1} << (shift - 1'b1);
        end
        w_sum = w_ext + w_rnd;
        w_shr = (SIGNED != 0) ? (w_sum >>> shift) : (w_sum >> shift);
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            r_s1 <= w_shr;
        end
    end

    always_comb begin
        w_clamp = r_s1[O_BW-1:0];
        w_sat   = 1'b0;
        if (SIGNED != 0) begin
            if (r_s1 > C_HI) begin
                w_clamp = C_HI[O_BW-1:0];
                w_sat   = 1'b1;
            end else if ((RELU != 0) && r_s1[XW-1]) begin
                w_clamp = '0;
            end else if (r_s1 < C_LO) begin
                w_clamp = C_LO[O_BW-1:0];
                w_sat   = 1'b1;
            end
        end else begin
            if ($unsigned(r_s1) > $unsigned(C_HI)) begin
                w_clamp = C_HI[O_BW-1:0];
                w_sat   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s2_load) begin
            r_q   <= w_clamp;
            r_sat <= w_sat;
        end
    end

    assign quant = r_q;
    assign sat   = r_sat;

endmodule
`default_nettype wire

// File: rtl/requantizer.sv
`default_nettype none
// ============================================================================
//  Module   : requantizer
//  Purpose  : NCH-wide 2-stage elastic requantizer with per-frame saturation count.
//  Revision : 1.0 - initial release
// ============================================================================
module requantizer
    import wrd_quant_pkg::*;
#(
    parameter int I_BW     = 32,
    parameter int O_BW     = 8,
    parameter int NCH      = 4,
    parameter int SHIFT_BW = $clog2(I_BW),
    parameter int SIGNED   = 1,
    parameter int RELU     = 0,
    parameter int ROUND    = 1,
    parameter int CNT_BW   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NCH*SHIFT_BW-1:0] shift_i,
    input  logic [NCH*I_BW-1:0]     data_i,
    input  logic                    valid_i,
    input  logic                    last_i,
    output logic                    ready_o,
    output logic [NCH*O_BW-1:0]     data_o,
    output logic                    valid_o,
    output logic                    last_o,
    input  logic                    ready_i,
    output logic [CNT_BW-1:0]       sat_cnt_o,
    output logic                    sat_cnt_valid_o
);

    localparam int BEAT_CNT_BW = $clog2(NCH + 1);

    logic r_s1_valid;
    logic r_s1_last;
    logic r_s2_valid;
    logic r_s2_last;
    logic w_out_hs;
    logic w_s2_ready;
    logic w_s1_adv;
    logic w_s1_load;

    assign w_out_hs   = r_s2_valid && ready_i;
    assign w_s2_ready = !r_s2_valid || ready_i;
    assign w_s1_adv   = r_s1_valid && w_s2_ready;
    assign ready_o    = !r_s1_valid || w_s1_adv;
    assign w_s1_load  = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            if (ready_o) begin
                r_s1_valid <= valid_i;
            end
            if (w_s1_load) begin
                r_s1_last <= last_i;
            end
            if (w_s2_ready) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv) begin
                r_s2_last <= r_s1_last;
            end
        end
    end

    logic [NCH-1:0] w_lane_sat;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_lane
            requantizer_lane #(
                .I_BW     (I_BW),
                .O_BW     (O_BW),
                .SHIFT_BW (SHIFT_BW),
                .SIGNED   (SIGNED),
                .RELU     (RELU),
                .ROUND    (ROUND)
            ) u_lane (
                .clk     (clk_i),
                .elem    (data_i[c*I_BW +: I_BW]),
                .shift   (shift_i[c*SHIFT_BW +: SHIFT_BW]),
                .s1_load (w_s1_load),
                .s2_load (w_s1_adv),
                .quant   (data_o[c*O_BW +: O_BW]),
                .sat     (w_lane_sat[c])
            );
        end
    endgenerate

    logic [BEAT_CNT_BW-1:0] w_beat_sat;
    logic [CNT_BW:0]        w_acc_sum;
    logic [CNT_BW-1:0]      w_acc_next;
    logic [CNT_BW-1:0]      r_acc;
    logic [CNT_BW-1:0]      r_sat_cnt;
    logic                   r_sat_cnt_valid;

    always_comb begin
        w_beat_sat = '0;
        for (int c = 0; c < NCH; c++) begin
            w_beat_sat = w_beat_sat + BEAT_CNT_BW'(w_lane_sat[c]);
        end
    end

    // The extra carry bit detects wrap so the accumulator pins at all-ones.
    assign w_acc_sum  = {1'b0, r_acc} + (CNT_BW+1)'(w_beat_sat);
    assign w_acc_next = w_acc_sum[CNT_BW] ? '1 : w_acc_sum[CNT_BW-1:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_acc           <= '0;
            r_sat_cnt       <= '0;
            r_sat_cnt_valid <= 1'b0;
        end else begin
            r_sat_cnt_valid <= 1'b0;
            if (w_out_hs) begin
                if (r_s2_last) begin
                    r_sat_cnt       <= w_acc_next;
                    r_sat_cnt_valid <= 1'b1;
                    r_acc           <= '0;
                end else begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

    assign valid_o         = r_s2_valid;
    assign last_o          = r_s2_last;
    assign sat_cnt_o       = r_sat_cnt;
    assign sat_cnt_valid_o = r_sat_cnt_valid;

endmodule
`default_nettype wire

// File: tb/tb_requantizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_requantizer
//  Purpose  : Self-checking bench: directed cases plus randomized traffic vs. a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_requantizer;

    localparam int I_BW     = 32;
    localparam int O_BW     = 8;
    localparam int NCH      = 2;
    localparam int SHIFT_BW = 5;
    localparam int CNT_BW   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH*SHIFT_BW-1:0] shift_i;
    logic [NCH*I_BW-1:0]     data_i;
    logic                    valid_i;
    logic                    last_i;
    logic                    ready_i;

    logic                ready_o_w  [2];
    logic [NCH*O_BW-1:0] data_o_w   [2];
    logic                valid_o_w  [2];
    logic                last_o_w   [2];
    logic [CNT_BW-1:0]   sat_cnt_w  [2];
    logic                sat_v_w    [2];

    requantizer #(.I_BW(I_BW), .O_BW(O_BW), .NCH(NCH), .SHIFT_BW(SHIFT_BW), .SIGNED(1),
                  .RELU(0), .ROUND(1), .CNT_BW(CNT_BW)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .shift_i(shift_i), .data_i(data_i),
        .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o_w[0]), .data_o(data_o_w[0]),
        .valid_o(valid_o_w[0]), .last_o(last_o_w[0]), .ready_i(ready_i),
        .sat_cnt_o(sat_cnt_w[0]), .sat_cnt_valid_o(sat_v_w[0]));

    requantizer #(.I_BW(I_BW), .O_BW(O_BW), .NCH(NCH), .SHIFT_BW(SHIFT_BW), .SIGNED(1),
                  .RELU(1), .ROUND(1), .CNT_BW(CNT_BW)) u_dut_relu (
        .clk_i(clk), .rst_n_i(rst_n), .shift_i(shift_i), .data_i(data_i),
        .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o_w[1]), .data_o(data_o_w[1]),
        .valid_o(valid_o_w[1]), .last_o(last_o_w[1]), .ready_i(ready_i),
        .sat_cnt_o(sat_cnt_w[1]), .sat_cnt_valid_o(sat_v_w[1]));

    typedef struct {
        logic [15:0] data;
        bit          last;
        int          nsat;
        int          in_cyc;
    } exp_t;

    exp_t        exp_q [2][$];
    int          acc_m [2];
    bit          sat_pend [2];
    int          sat_exp [2];
    bit          hold [2];
    logic [15:0] hold_data [2];

    int n_cmp;
    int n_err;
    int n_push;
    int cyc = 0;
    bit lat_chk;
    bit rnd_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic on a 64-bit value, then clamp.
    function automatic int ref_q(input int x, input int sh, input bit relu, output bit sat);
        longint v;
        sat = 1'b0;
        v = longint'(x);
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 127) begin sat = 1'b1; return 127; end
        if (relu && v < 0) return 0;
        if (v < -128) begin sat = 1'b1; return -128; end
        return int'(v);
    endfunction

    task automatic push_exp(input int k);
        exp_t e;
        int   q;
        bit   s;
        e.data = '0;
        e.nsat = 0;
        for (int c = 0; c < NCH; c++) begin
            q = ref_q(int'(data_i[c*I_BW +: I_BW]), int'(shift_i[c*SHIFT_BW +: SHIFT_BW]), k == 1, s);
            e.data[c*O_BW +: O_BW] = q[7:0];
            e.nsat += int'(s);
        end
        e.last   = last_i;
        e.in_cyc = cyc;
        exp_q[k].push_back(e);
        if (k == 0) n_push++;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            acc_m[k]    = 0;
            sat_pend[k] = 1'b0;
            hold[k]     = 1'b0;
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            for (int k = 0; k < 2; k++) begin
                if (sat_pend[k] || sat_v_w[k]) begin
                    chk($sformatf("sat_valid%0d", k), longint'(sat_v_w[k]), longint'(sat_pend[k]));
                    if (sat_pend[k]) chk($sformatf("sat_cnt%0d", k), longint'(sat_cnt_w[k]), sat_exp[k]);
                    sat_pend[k] = 1'b0;
                end
                if (hold[k]) begin
                    chk($sformatf("hold_valid%0d", k), longint'(valid_o_w[k]), 1);
                    chk($sformatf("hold_data%0d", k), longint'(data_o_w[k]), longint'(hold_data[k]));
                end
                hold[k]      = valid_o_w[k] && !ready_i;
                hold_data[k] = data_o_w[k];
                if (valid_o_w[k] && ready_i) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("spurious_beat%0d", k), 1, 0);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("data%0d", k), longint'(data_o_w[k]), longint'(e.data));
                        chk($sformatf("last%0d", k), longint'(last_o_w[k]), longint'(e.last));
                        if (lat_chk) chk($sformatf("latency%0d", k), cyc - e.in_cyc, 2);
                        acc_m[k] = acc_m[k] + e.nsat;
                        if (acc_m[k] > 65535) acc_m[k] = 65535;
                        if (e.last) begin
                            sat_exp[k]  = acc_m[k];
                            sat_pend[k] = 1'b1;
                            acc_m[k]    = 0;
                        end
                    end
                end
                if (valid_i && ready_o_w[k]) push_exp(k);
            end
        end
    endtask

    // Entered and left at posedge+1; handshake seen at the negedge before the edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input int sa, input int sb, input bit l);
        bit hs;
        data_i  = {b, a};
        shift_i = {5'(sb), 5'(sa)};
        last_i  = l;
        valid_i = 1'b1;
        hs      = 1'b0;
        for (int t = 0; t < 200 && !hs; t++) begin
            @(negedge clk);
            hs = ready_o_w[0];
        end
        if (!hs) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic wait_out(input int k);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = valid_o_w[k];
        end
        if (!seen) chk("out_timeout", 0, 1);
    endtask

    task automatic wait_sat(input int k);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = sat_v_w[k];
        end
        if (!seen) chk("sat_timeout", 0, 1);
    endtask

    function automatic logic [31:0] rnd_elem();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 600)) - 32'd300;
            1:       return 32'($urandom);
            2:       return 32'($urandom_range(0, 4000)) - 32'd2000;
            default: return ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
    endfunction

    function automatic int rnd_shift();
        return ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 31));
    endfunction

    initial begin
        int base;
        n_cmp   = 0;
        n_err   = 0;
        n_push  = 0;
        lat_chk = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        data_i  = '0;
        shift_i = '0;
        ready_i = 1'b1;
        clear_model();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        fork
            monitor();
        join_none

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid_o", longint'(valid_o_w[k]), 0);
            chk("rst_sat_valid", longint'(sat_v_w[k]), 0);
            chk("rst_sat_cnt", longint'(sat_cnt_w[k]), 0);
            chk("rst_ready_o", longint'(ready_o_w[k]), 1);
        end
        @(posedge clk);
        #1;

        // Rounding shift and two-cycle latency
        lat_chk = 1'b1;
        send(32'd24, -32'sd24, 4, 4, 1'b0);
        wait_out(0);
        chk("round_shift", longint'(data_o_w[0]), 16'hFF02);
        @(posedge clk);
        #1;
        lat_chk = 1'b0;

        // Both-direction saturation, frame closes with two saturations
        send(32'h7FFF_FFFF, -32'sd1000, 0, 0, 1'b1);
        wait_out(0);
        chk("clamp_pair", longint'(data_o_w[0]), 16'h807F);
        chk("clamp_pair_relu", longint'(data_o_w[1]), 16'h007F);
        wait_sat(0);
        chk("frame_sat_2", longint'(sat_cnt_w[0]), 2);
        chk("frame_sat_relu_1", longint'(sat_cnt_w[1]), 1);
        @(posedge clk);
        #1;

        // Four-beat frame, three saturated elements
        send(32'd1000, 32'd0, 0, 0, 1'b0);
        send(-32'sd500, 32'd5, 0, 0, 1'b0);
        send(32'd1, 32'd200, 0, 0, 1'b0);
        send(32'd3, 32'd4, 0, 0, 1'b1);
        wait_sat(0);
        chk("frame_sat_3", longint'(sat_cnt_w[0]), 3);
        @(negedge clk);
        chk("sat_pulse_once", longint'(sat_v_w[0]), 0);
        chk("sat_cnt_held", longint'(sat_cnt_w[0]), 3);
        @(posedge clk);
        #1;

        // ReLU zeroing is not a saturation
        send(-32'sd5, 32'd300, 1, 1, 1'b1);
        wait_out(1);
        chk("relu_out", longint'(data_o_w[1]), 16'h7F00);
        chk("norelu_out", longint'(data_o_w[0]), 16'h7FFE);
        wait_sat(1);
        chk("relu_frame_cnt", longint'(sat_cnt_w[1]), 1);
        @(posedge clk);
        #1;

        // Backpressure: ten-beat stream, downstream stalled for three cycles
        base = n_push;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(32'(i * 1000 - 3000), 32'(i * 37), 2, 0, i == 9);
                end
            end
            begin
                ready_i = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                chk("bp_accepted", n_push - base, 2);
                chk("bp_ready_low", longint'(ready_o_w[0]), 0);
                @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        chk("bp_drained", exp_q[0].size(), 0);
        chk("bp_all_in", n_push - base, 10);

        // Reset with a partial count and two beats in flight
        send(32'd100000, 32'd0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        ready_i = 1'b0;
        send(32'd7, 32'd8, 0, 0, 1'b0);
        send(32'd9, 32'd10, 0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrst_valid_o", longint'(valid_o_w[k]), 0);
            chk("midrst_sat_cnt", longint'(sat_cnt_w[k]), 0);
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("postrst_idle", longint'(valid_o_w[0]), 0);
        send(32'd1000, -32'sd2000, 0, 0, 1'b1);
        wait_sat(0);
        chk("postrst_frame_cnt", longint'(sat_cnt_w[0]), 2);
        @(posedge clk);
        #1;

        // Randomized traffic with random downstream stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    send(rnd_elem(), rnd_elem(), rnd_shift(), rnd_shift(),
                         (i == 249) || ($urandom_range(0, 3) == 0));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("final_drain0", exp_q[0].size(), 0);
        chk("final_drain1", exp_q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
